// File: rtl/reg_read_stage.sv
// -----------------------------------------------------------------------------
// reg_read_stage
//
// Register-read pipeline stage. It holds a 16 x 16-bit register file (r0 is
// hard-wired to zero), forms three read addresses from the incoming instruction
// fields, and latches the operands plus decoded opcode/func/dest into an output
// register guarded by a valid/ready handshake. A load-use interlock stalls the
// upstream side when the instruction after a load reads the load destination.
//
// Parameters
//   LOAD_STALL   bubble cycles inserted on a load-use hazard (1..7)
//
// Ports
//   clk                  sole clock, rising edge
//   reset_n              asynchronous active-low reset
//   in_valid / in_ready  upstream handshake
//   instr[15:0]          opcode[15:12] fieldA[11:8] fieldB[7:4] fieldC[3:0]
//   ReadRegSrc1/2/3      read-address select bits from the decoder
//   wb_en/wb_addr/wb_data  register-file writeback port
//   out_valid/out_ready  downstream handshake
//   out_opa/opb/opc      latched operands
//   out_opcode/out_func/out_dest  latched decode fields (dest = fieldA)
//
// Configuration
//   RR_FORWARD_EN  when defined, a same-cycle writeback to a read address is
//                  forwarded into the latched operand; otherwise the operand
//                  holds the pre-write register contents.
// -----------------------------------------------------------------------------
module reg_read_stage #(
  parameter int LOAD_STALL = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  input  logic        ReadRegSrc1,
  input  logic        ReadRegSrc2,
  input  logic        ReadRegSrc3,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_opa,
  output logic [15:0] out_opb,
  output logic [15:0] out_opc,
  output logic [3:0]  out_opcode,
  output logic [1:0]  out_func,
  output logic [3:0]  out_dest
);

  localparam logic [3:0] OPC_LWD = 4'b0001;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Register file: one flop group per register, r0 is a constant zero.
  // ---------------------------------------------------------------------------
  logic [15:0][15:0] rf_rd;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf_rd[gi] = 16'h0000;
      end else begin : g_reg
        logic [15:0] reg_q;
        logic [15:0] reg_d;

        always_comb begin
          reg_d = reg_q;
          if (wb_en && (wb_addr == 4'(gi))) begin
            reg_d = wb_data;
          end
        end

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            reg_q <= 16'h0000;
          end else begin
            reg_q <= reg_d;
          end
        end

        assign rf_rd[gi] = reg_q;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Instruction decode and read-address formation. Only an explicit 1 picks
  // the alternate field, so an unknown select falls back to the primary one.
  // ---------------------------------------------------------------------------
  logic [3:0] opcode, field_a, field_b, field_c;
  logic [1:0] func;
  logic [3:0] addr_a, addr_b, addr_c;

  assign opcode  = instr[15:12];
  assign field_a = instr[11:8];
  assign field_b = instr[7:4];
  assign field_c = instr[3:0];
  assign func    = instr[1:0];

  assign addr_a = (ReadRegSrc1 === 1'b1) ? field_b : field_a;
  assign addr_b = (ReadRegSrc2 === 1'b1) ? field_c : field_b;
  assign addr_c = (ReadRegSrc3 === 1'b1) ? field_a : field_c;

  logic [15:0] rd_a, rd_b, rd_c;

`ifdef RR_FORWARD_EN
  logic wb_fwd;
  assign wb_fwd = wb_en && (wb_addr != 4'd0);
  assign rd_a = (wb_fwd && (wb_addr == addr_a)) ? wb_data : rf_rd[addr_a];
  assign rd_b = (wb_fwd && (wb_addr == addr_b)) ? wb_data : rf_rd[addr_b];
  assign rd_c = (wb_fwd && (wb_addr == addr_c)) ? wb_data : rf_rd[addr_c];
`else
  assign rd_a = rf_rd[addr_a];
  assign rd_b = rf_rd[addr_b];
  assign rd_c = rf_rd[addr_c];
`endif

  // ---------------------------------------------------------------------------
  // Handshake, hazard detection and stall FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [3:0]  pend_addr_q, pend_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] opa_q, opa_d, opb_q, opb_d, opc_q, opc_d;
  logic [3:0]  opcode_q, opcode_d, dest_q, dest_d;
  logic [1:0]  func_q, func_d;

  logic hazard;
  logic transfer;

  // Pending dest is always nonzero, so r0 reads never hazard.
  assign hazard = in_valid && pend_vld_q &&
                  ((pend_addr_q == addr_a) || (pend_addr_q == addr_b));

  assign in_ready = (!out_valid_q || out_ready) && (state_q == ST_RUN) && !hazard;
  assign transfer = in_valid && in_ready;

  // The hazard-detect cycle is itself the first bubble, so STALL lasts
  // LOAD_STALL-1 cycles; with LOAD_STALL=1 the FSM stays in RUN and just
  // retires the pending load.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;

    case (state_q)
      ST_RUN: begin
        if (hazard) begin
          cnt_d = 3'(LOAD_STALL - 1);
          if (LOAD_STALL > 1) begin
            state_d = ST_STALL;
          end else begin
            pend_vld_d = 1'b0;
          end
        end else if (transfer) begin
          if ((opcode == OPC_LWD) && (field_a != 4'd0)) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = field_a;
          end else begin
            pend_vld_d  = 1'b0;
          end
        end
      end
      ST_STALL: begin
        cnt_d = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
        if (cnt_d == 3'd0) begin
          state_d    = ST_RUN;
          pend_vld_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output register: load on transfer, hold under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    opc_d       = opc_q;
    opcode_d    = opcode_q;
    func_d      = func_q;
    dest_d      = dest_q;

    if (transfer) begin
      out_valid_d = 1'b1;
      opa_d       = rd_a;
      opb_d       = rd_b;
      opc_d       = rd_c;
      opcode_d    = opcode;
      func_d      = func;
      dest_d      = field_a;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= 3'd0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= 4'd0;
      out_valid_q <= 1'b0;
      opa_q       <= 16'h0000;
      opb_q       <= 16'h0000;
      opc_q       <= 16'h0000;
      opcode_q    <= 4'd0;
      func_q      <= 2'd0;
      dest_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      out_valid_q <= out_valid_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opc_q       <= opc_d;
      opcode_q    <= opcode_d;
      func_q      <= func_d;
      dest_q      <= dest_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_opa    = opa_q;
  assign out_opb    = opb_q;
  assign out_opc    = opc_q;
  assign out_opcode = opcode_q;
  assign out_func   = func_q;
  assign out_dest   = dest_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// -----------------------------------------------------------------------------
// tb_reg_read_stage
//
// Directed testbench for reg_read_stage (LOAD_STALL = 2). Each scenario task
// drives stimulus and compares outputs against hand-computed values. Inputs are
// driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_reg_read_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        ReadRegSrc1, ReadRegSrc2, ReadRegSrc3;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_opa, out_opb, out_opc;
  logic [3:0]  out_opcode;
  logic [1:0]  out_func;
  logic [3:0]  out_dest;

  int n_checks = 0;
  int n_fail   = 0;

  reg_read_stage #(.LOAD_STALL(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .ReadRegSrc1(ReadRegSrc1),
    .ReadRegSrc2(ReadRegSrc2),
    .ReadRegSrc3(ReadRegSrc3),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opa    (out_opa),
    .out_opb    (out_opb),
    .out_opc    (out_opc),
    .out_opcode (out_opcode),
    .out_func   (out_func),
    .out_dest   (out_dest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
    $display("wb r%0d <= %h", a, d);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if ({out_opa, out_opb, out_opc} !== 48'h0) begin
      n_fail++; $display("FAIL reset_operands: got %h %h %h want 0", out_opa, out_opb, out_opc);
    end
    n_checks++;
    if ({out_opcode, out_func, out_dest} !== 10'h0) begin
      n_fail++; $display("FAIL reset_decode: got op=%h func=%h dest=%h want 0", out_opcode, out_func, out_dest);
    end
    step();
    reset_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    $display("reset: out_valid=%b in_ready=%b", out_valid, in_ready);
  endtask

  task automatic test_write_read();
    wb_write(4'd3, 16'h1234);
    instr = 16'h8345; {ReadRegSrc1, ReadRegSrc2, ReadRegSrc3} = 3'b000;
    in_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wr_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wr_out_valid: got %b want 1", out_valid); end
    n_checks++;
    if (out_opa !== 16'h1234 || out_opb !== 16'h0 || out_opc !== 16'h0) begin
      n_fail++; $display("FAIL wr_operands: got %h %h %h want 1234 0000 0000", out_opa, out_opb, out_opc);
    end
    n_checks++;
    if (out_dest !== 4'd3 || out_opcode !== 4'h8 || out_func !== 2'd1) begin
      n_fail++; $display("FAIL wr_decode: got dest=%h op=%h func=%h want 3 8 1", out_dest, out_opcode, out_func);
    end
    $display("write_read: instr=8345 opa=%h dest=%h opcode=%h", out_opa, out_dest, out_opcode);
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wr_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_selects();
    wb_write(4'd1, 16'd1);
    wb_write(4'd2, 16'd2);
    wb_write(4'd3, 16'd3);
    instr = 16'h1123; {ReadRegSrc1, ReadRegSrc2, ReadRegSrc3} = 3'b111;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_opa !== 16'd2 || out_opb !== 16'd3 || out_opc !== 16'd1) begin
      n_fail++; $display("FAIL sel_operands: got %h %h %h want 0002 0003 0001", out_opa, out_opb, out_opc);
    end
    n_checks++;
    if (out_func !== 2'd3 || out_dest !== 4'd1) begin
      n_fail++; $display("FAIL sel_decode: got func=%h dest=%h want 3 1", out_func, out_dest);
    end
    $display("selects: instr=1123 opa=%h opb=%h opc=%h", out_opa, out_opb, out_opc);
    {ReadRegSrc1, ReadRegSrc2, ReadRegSrc3} = 3'b000;
    step();
  endtask

  task automatic test_load_use();
    int low;
    // lwd r5 (reads r5/r2, neither matches pending r1 from the previous test)
    instr = 16'h1520; in_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_lwd_accept: got %b want 1", in_ready); end
    step();
    // dependent instruction reads r5 as operand B
    instr = 16'h2650;
    #1;
    low = 0;
    while (in_ready !== 1'b1 && low < 20) begin
      low++;
      step();
    end
    n_checks++;
    if (low != 2) begin n_fail++; $display("FAIL lu_stall_cycles: got %0d want 2", low); end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_opcode !== 4'h2 || out_dest !== 4'd6 || out_opb !== 16'h0) begin
      n_fail++; $display("FAIL lu_accepted: got v=%b op=%h dest=%h opb=%h want 1 2 6 0000",
                         out_valid, out_opcode, out_dest, out_opb);
    end
    $display("load_use: stall cycles=%0d then opcode=%h dest=%h", low, out_opcode, out_dest);
    step();
  endtask

  task automatic test_back_to_back();
    wb_write(4'd10, 16'h00AA);
    out_ready = 1'b0;
    instr = 16'h9ABC; in_valid = 1'b1;
    step();
    instr = 16'h3123;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_opa !== 16'h00AA ||
          out_dest !== 4'd10 || out_opcode !== 4'h9) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b opa=%h dest=%h op=%h want 0 1 00aa a 9",
                           i, in_ready, out_valid, out_opa, out_dest, out_opcode);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_opa !== 16'd1 || out_opb !== 16'd2 || out_opc !== 16'd3 ||
        out_dest !== 4'd1 || out_opcode !== 4'h3) begin
      n_fail++; $display("FAIL bp_same_edge: got v=%b %h %h %h dest=%h op=%h want 1 0001 0002 0003 1 3",
                         out_valid, out_opa, out_opb, out_opc, out_dest, out_opcode);
    end
    $display("back_to_back: held 4 cycles, then opa=%h opcode=%h", out_opa, out_opcode);
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_forward();
    logic [15:0] exp_a;
`ifdef RR_FORWARD_EN
    exp_a = 16'hBEEF;
`else
    exp_a = 16'h0000;
`endif
    instr = 16'h4700; in_valid = 1'b1;
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 16'hBEEF;
    step();
    wb_en = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_opa !== exp_a) begin n_fail++; $display("FAIL fwd_same_cycle: got %h want %h", out_opa, exp_a); end
    $display("forward: same-cycle opa=%h", out_opa);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_opa !== 16'hBEEF) begin n_fail++; $display("FAIL fwd_after_write: got %h want beef", out_opa); end
    step();
  endtask

  task automatic test_reset_mid_stall();
    instr = 16'h1900; in_valid = 1'b1;
    step();
    instr = 16'h2090;          // reads r9 as operand B -> hazard
    step();
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_stall_entered: got %b want 0", in_ready); end
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_opa !== 16'h0 || out_dest !== 4'd0 || out_opcode !== 4'd0) begin
      n_fail++; $display("FAIL rst_async: got v=%b opa=%h dest=%h op=%h want 0", out_valid, out_opa, out_dest, out_opcode);
    end
    step();
    reset_n = 1'b1;
    instr = 16'h5370; in_valid = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_opa !== 16'h0 || out_opb !== 16'h0 || out_opcode !== 4'h5) begin
      n_fail++; $display("FAIL rst_regs_cleared: got v=%b opa=%h opb=%h op=%h want 1 0000 0000 5",
                         out_valid, out_opa, out_opb, out_opcode);
    end
    $display("reset_mid_stall: after reset opa=%h opb=%h", out_opa, out_opb);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; instr = 16'h0;
    ReadRegSrc1 = 1'b0; ReadRegSrc2 = 1'b0; ReadRegSrc3 = 1'b0;
    wb_en = 1'b0; wb_addr = 4'd0; wb_data = 16'h0; out_ready = 1'b1;

    test_reset();
    test_write_read();
    test_selects();
    test_load_use();
    test_back_to_back();
    test_forward();
    test_reset_mid_stall();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
